// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Purpose  : Prioritises interrupt/branch/j/jr redirects for the dual-slot IF
//            stage, hands one PC to the fetch PC register and sequences flushes.
//            Optional completed-redirect counter: define REDIR_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          JR_TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        int_req,
    input  logic        br_req,
    input  logic        br_slot,
    input  logic [31:0] br_target,
    input  logic        j_req,
    input  logic [31:0] j_target,
    input  logic        jr_req,
    input  logic [31:0] jr_data,
    input  logic        jr_data_ok,
    input  logic        redir_ready,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        if_flush,
    output logic        id_flush,
    output logic        busy,
    output logic        jr_err,
    output logic [15:0] redir_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_JR = 2'd1,
        ISSUE   = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] JR_LAST    = 8'(JR_TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic [31:0] redir_pc_q,  redir_pc_d;
    logic        kill_id_q,   kill_id_d;
    logic [7:0]  jr_cnt_q,    jr_cnt_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        int_pend_q,  int_pend_d;
    logic        jr_err_q,    jr_err_d;
    logic        xfer;

    assign xfer = (state_q == ISSUE) && redir_ready && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            redir_pc_q  <= RESET_PC;
            kill_id_q   <= 1'b0;
            jr_cnt_q    <= 8'd0;
            flush_cnt_q <= 2'd0;
            int_pend_q  <= 1'b0;
            jr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            redir_pc_q  <= redir_pc_d;
            kill_id_q   <= kill_id_d;
            jr_cnt_q    <= jr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            int_pend_q  <= int_pend_d;
            jr_err_q    <= jr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        redir_pc_d  = redir_pc_q;
        kill_id_d   = kill_id_q;
        jr_cnt_d    = jr_cnt_q;
        flush_cnt_d = flush_cnt_q;
        int_pend_d  = int_pend_q;
        jr_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // An interrupt latched during FLUSH outranks anything new.
                if (int_pend_q || int_req) begin
                    redir_pc_d = EXC_VECTOR;
                    kill_id_d  = 1'b1;
                    int_pend_d = 1'b0;
                    state_d    = ISSUE;
                end else if (br_req) begin
                    redir_pc_d = br_target;
                    kill_id_d  = !br_slot;
                    state_d    = ISSUE;
                end else if (j_req) begin
                    redir_pc_d = j_target;
                    kill_id_d  = 1'b1;
                    state_d    = ISSUE;
                end else if (jr_req) begin
                    kill_id_d = 1'b1;
                    if (jr_data_ok) begin
                        redir_pc_d = jr_data;
                        state_d    = ISSUE;
                    end else begin
                        jr_cnt_d = 8'd0;
                        state_d  = WAIT_JR;
                    end
                end
            end
            WAIT_JR: begin
                if (int_req) begin
                    redir_pc_d = EXC_VECTOR;
                    kill_id_d  = 1'b1;
                    state_d    = ISSUE;
                end else if (jr_data_ok) begin
                    redir_pc_d = jr_data;
                    state_d    = ISSUE;
                end else if (jr_cnt_q == JR_LAST) begin
                    jr_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    jr_cnt_d = jr_cnt_q + 8'd1;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    flush_cnt_d = 2'd0;
                    state_d     = FLUSH;
                    // The offered PC is already gone; keep the interrupt for later.
                    if (int_req) int_pend_d = 1'b1;
                end else if (int_req) begin
                    redir_pc_d = EXC_VECTOR;
                    kill_id_d  = 1'b1;
                end
            end
            FLUSH: begin
                if (int_req) int_pend_d = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign redir_valid = (state_q == ISSUE);
    assign redir_pc    = redir_pc_q;
    assign if_flush    = (state_q == FLUSH);
    assign id_flush    = (state_q == FLUSH) && (flush_cnt_q == 2'd0) && kill_id_q;
    assign busy        = (state_q != IDLE);
    assign jr_err      = jr_err_q;

`ifdef REDIR_STAT_EN
    logic [15:0] redir_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_cnt_q <= 16'd0;
        end else if (xfer && (redir_cnt_q != 16'hFFFF)) begin
            redir_cnt_q <= redir_cnt_q + 16'd1;
        end
    end

    assign redir_cnt = redir_cnt_q;
`else
    assign redir_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_ctrl
// Purpose  : Directed self-checking bench for fetch_redirect_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] EXC = 32'hBFC0_0380;
    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        int_req = 1'b0;
    logic        br_req = 1'b0;
    logic        br_slot = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        j_req = 1'b0;
    logic [31:0] j_target = 32'h0;
    logic        jr_req = 1'b0;
    logic [31:0] jr_data = 32'h0;
    logic        jr_data_ok = 1'b0;
    logic        redir_ready = 1'b1;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        if_flush;
    logic        id_flush;
    logic        busy;
    logic        jr_err;
    logic [15:0] redir_cnt;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .int_req(int_req),
        .br_req(br_req), .br_slot(br_slot), .br_target(br_target),
        .j_req(j_req), .j_target(j_target), .jr_req(jr_req),
        .jr_data(jr_data), .jr_data_ok(jr_data_ok), .redir_ready(redir_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .if_flush(if_flush),
        .id_flush(id_flush), .busy(busy), .jr_err(jr_err), .redir_cnt(redir_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && busy; i++) step();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s idle-timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(); step();
        compared++;
        if ({redir_valid, if_flush, id_flush, busy, jr_err} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: v/if/id/busy/err=%b required 00000",
                     {redir_valid, if_flush, id_flush, busy, jr_err});
        end
        compared++;
        if (redir_pc !== RPC) begin
            mismatched++;
            $display("FAIL reset_pc: got %h required %h", redir_pc, RPC);
        end
        compared++;
        if (redir_cnt !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_cnt: got %h required 0000", redir_cnt);
        end
        reset = 1'b0;
        step();
        compared++;
        if (busy !== 1'b0 || redir_pc !== RPC) begin
            mismatched++;
            $display("FAIL reset_idle: busy=%b pc=%h required 0 %h", busy, redir_pc, RPC);
        end
    endtask

    task automatic test_branch(input logic slot, input logic [31:0] tgt);
        br_req = 1'b1; br_slot = slot; br_target = tgt; redir_ready = 1'b1;
        step();
        br_req = 1'b0;
        compared++;
        if (redir_valid !== 1'b1 || redir_pc !== tgt || if_flush !== 1'b0) begin
            mismatched++;
            $display("FAIL br%0d_issue: v=%b pc=%h if=%b required 1 %h 0",
                     slot, redir_valid, redir_pc, if_flush, tgt);
        end
        step();
        compared++;
        if (if_flush !== 1'b1 || id_flush !== !slot || redir_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL br%0d_flush: if=%b id=%b v=%b required 1 %b 0",
                     slot, if_flush, id_flush, redir_valid, !slot);
        end
        step();
        compared++;
        if (busy !== 1'b0 || if_flush !== 1'b0 || id_flush !== 1'b0) begin
            mismatched++;
            $display("FAIL br%0d_done: busy=%b if=%b id=%b required 0 0 0",
                     slot, busy, if_flush, id_flush);
        end
    endtask

    task automatic test_priority;
        logic seen_bad = 1'b0;
        int_req = 1'b1; br_req = 1'b1; br_slot = 1'b1; br_target = 32'h1111_0000;
        j_req = 1'b1; j_target = 32'h2222_0000;
        step();
        int_req = 1'b0; br_req = 1'b0; j_req = 1'b0;
        compared++;
        if (redir_valid !== 1'b1 || redir_pc !== EXC) begin
            mismatched++;
            $display("FAIL prio_issue: v=%b pc=%h required 1 %h", redir_valid, redir_pc, EXC);
        end
        step();
        compared++;
        if (if_flush !== 1'b1 || id_flush !== 1'b1) begin
            mismatched++;
            $display("FAIL prio_flush: if=%b id=%b required 1 1", if_flush, id_flush);
        end
        for (int i = 0; i < 4; i++) begin
            if (redir_pc === 32'h1111_0000 || redir_pc === 32'h2222_0000) seen_bad = 1'b1;
            step();
        end
        compared++;
        if (seen_bad !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL prio_drop: stray_target=%b busy=%b required 0 0", seen_bad, busy);
        end
    endtask

    task automatic test_jr_wait;
        jr_req = 1'b1; jr_data_ok = 1'b0;
        step();
        jr_req = 1'b0;
        step(); step();
        compared++;
        if (busy !== 1'b1 || redir_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL jr_wait: busy=%b v=%b required 1 0", busy, redir_valid);
        end
        jr_data = 32'h8000_1234; jr_data_ok = 1'b1;
        step();
        jr_data_ok = 1'b0;
        compared++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_1234) begin
            mismatched++;
            $display("FAIL jr_data: v=%b pc=%h required 1 80001234", redir_valid, redir_pc);
        end
        wait_idle("jr_data");
    endtask

    task automatic test_jr_timeout;
        int pulses = 0;
        int pulse_at = 0;
        logic v_seen = 1'b0;
        jr_req = 1'b1; jr_data_ok = 1'b0;
        step();
        jr_req = 1'b0;
        for (int i = 2; i <= 22; i++) begin
            step();
            if (jr_err === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            if (redir_valid !== 1'b0) v_seen = 1'b1;
        end
        compared++;
        if (pulses != 1 || pulse_at != 17) begin
            mismatched++;
            $display("FAIL jr_timeout: pulses=%0d at_cycle=%0d required 1 17", pulses, pulse_at);
        end
        compared++;
        if (v_seen !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL jr_noredir: valid_seen=%b busy=%b required 0 0", v_seen, busy);
        end
    endtask

    task automatic test_stall;
        logic held_ok = 1'b1;
        stall = 1'b1; br_req = 1'b1; br_slot = 1'b0; br_target = 32'h8000_0800;
        step();
        br_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_0800 || if_flush !== 1'b0)
                held_ok = 1'b0;
            step();
        end
        compared++;
        if (held_ok !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_hold: held=%b required 1 (v=%b pc=%h)", held_ok, redir_valid, redir_pc);
        end
        stall = 1'b0;
        step();
        compared++;
        if (if_flush !== 1'b1 || redir_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_release: if=%b v=%b required 1 0", if_flush, redir_valid);
        end
        wait_idle("stall");
    endtask

    task automatic test_reset_mid_issue;
        redir_ready = 1'b0; j_req = 1'b1; j_target = 32'h8000_0200;
        step();
        j_req = 1'b0;
        compared++;
        if (redir_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rmi_issue: v=%b required 1", redir_valid);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if (redir_valid !== 1'b0 || busy !== 1'b0 || redir_pc !== RPC || redir_cnt !== 16'h0) begin
            mismatched++;
            $display("FAIL rmi_async: v=%b busy=%b pc=%h cnt=%h required 0 0 %h 0000",
                     redir_valid, busy, redir_pc, redir_cnt, RPC);
        end
        redir_ready = 1'b1;
        step();
        reset = 1'b0;
        step();
        compared++;
        if (busy !== 1'b0 || redir_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rmi_discard: busy=%b v=%b required 0 0", busy, redir_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_cnt;
`ifdef REDIR_STAT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        br_req = 1'b1; br_slot = 1'b1; br_target = 32'h8000_0040;
        step();
        br_req = 1'b0;
        step();
        int_req = 1'b1;
        step();
        int_req = 1'b0;
        step();
        compared++;
        if (redir_valid !== 1'b1 || redir_pc !== EXC) begin
            mismatched++;
            $display("FAIL pend_int: v=%b pc=%h required 1 %h", redir_valid, redir_pc, EXC);
        end
        wait_idle("pend_int");
        j_req = 1'b1; j_target = 32'h8000_0300;
        step();
        j_req = 1'b0;
        wait_idle("third");
        compared++;
        if (redir_cnt !== exp_cnt) begin
            mismatched++;
            $display("FAIL redir_cnt: got %0d required %0d", redir_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_branch(1'b0, 32'hBFC0_0100);
        test_branch(1'b1, 32'h8000_0040);
        test_priority();
        test_jr_wait();
        test_jr_timeout();
        test_stall();
        test_reset_mid_issue();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequences all fetch-PC redirects for the dual-slot IF stage. Captures interrupt, conditional branch (slot 1 or slot 2), j and jr requests and resolves them by priority. For jr it waits for the register operand. It then presents one redirect PC to the fetch PC register with a valid/ready handshake and drives the IF/ID flush pulses that follow each redirect.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, interrupt/exception redirect target
RESET_PC, 32'hBFC0_0000, value held on redir_pc while idle after reset
FLUSH_CYCLES, 1, number of cycles if_flush is held after a redirect is accepted (1..3)
JR_TIMEOUT, 16, maximum WAIT_JR cycles before abort (>=1, 8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline hold (hard or soft delay); blocks redirect transfer
int_req  in  1  interrupt/exception redirect request
br_req  in  1  taken conditional branch
br_slot  in  1  0 = branch issued in slot 1, 1 = slot 2
br_target  in  32  branch target PC
j_req  in  1  j/jal request
j_target  in  32  jump target PC
jr_req  in  1  jr/jalr request
jr_data  in  32  jr register operand
jr_data_ok  in  1  jr_data valid this cycle
redir_ready  in  1  fetch PC register can load redir_pc
redir_valid  out  1  redirect PC offered
redir_pc  out  32  redirect target
if_flush  out  1  kill in-flight fetch
id_flush  out  1  kill instruction in ID (slot-1 branch shadow or interrupt)
busy  out  1  state != IDLE
jr_err  out  1  one-cycle pulse on jr timeout
redir_cnt  out  16  completed-redirect count (see Optional Feature)

Behaviour:
- Reset: state IDLE. redir_valid, if_flush, id_flush, jr_err = 0. busy = 0. redir_pc = RESET_PC. counters = 0. Reset applies from any state, mid-redirect included; a pending request is discarded.
- States: IDLE, WAIT_JR, ISSUE, FLUSH. All requests are sampled at posedge clk.
- IDLE, request priority int > br > j > jr; lower-priority requests in the same cycle are dropped.
  - int: redir_pc <= EXC_VECTOR, kill_id <= 1, go to ISSUE.
  - br: redir_pc <= br_target, kill_id <= (br_slot==0), go to ISSUE.
  - j: redir_pc <= j_target, kill_id <= 1, go to ISSUE.
  - jr with jr_data_ok=1 in the same cycle: redir_pc <= jr_data, kill_id <= 1, go to ISSUE.
  - jr with jr_data_ok=0: clear the timeout counter, go to WAIT_JR.
- WAIT_JR:
  - int_req preempts: load EXC_VECTOR, go to ISSUE.
  - jr_data_ok=1: redir_pc <= jr_data, go to ISSUE.
  - Otherwise the counter increments. When the counter reaches JR_TIMEOUT-1 with no data: jr_err=1 for one cycle, go to IDLE, no redirect.
- ISSUE: redir_valid=1 and redir_pc stable.
  - Transfer occurs on a cycle with redir_valid & redir_ready & !stall; next state FLUSH.
  - If stall or !redir_ready, hold indefinitely.
  - int_req while in ISSUE (pre-transfer) overwrites redir_pc with EXC_VECTOR and sets kill_id=1; transfer rules are unchanged.
- FLUSH: redir_valid=0. if_flush=1 for FLUSH_CYCLES cycles. id_flush=kill_id on the first FLUSH cycle only. Then go to IDLE.
  - int_req in FLUSH is latched as a pending interrupt and serviced on entry to IDLE, taking priority over new requests that cycle.
- br/j/jr arriving in WAIT_JR, ISSUE or FLUSH are ignored; the shadowed instruction is flushed upstream.
- stall does not block capture in IDLE or progress in WAIT_JR or FLUSH. It only blocks the ISSUE transfer.
- Minimum latency, request to redir_valid: 1 cycle (non-jr, or jr with data). Request to if_flush: 2 cycles when redir_ready=1.

Optional Feature:
REDIR_STAT_EN
- Defined: redir_cnt increments by 1 on every accepted transfer, saturating at 16'hFFFF. Reset to 0.
- Undefined: no counter logic; redir_cnt is tied to 16'h0000.

Test Plan:
- Reset released, then br_req=1, br_slot=0, br_target=32'hBFC0_0100, redir_ready=1 -> redir_valid=1 and redir_pc=32'hBFC0_0100 the next cycle; if_flush=1 and id_flush=1 the cycle after; busy low after FLUSH_CYCLES.
- Slot-2 branch: br_slot=1, br_target=32'h8000_0040 -> same timing as above, but id_flush stays 0 throughout.
- Simultaneous int_req, br_req and j_req -> redir_pc=32'hBFC0_0380; branch and jump targets never appear on redir_pc.
- jr_req with jr_data_ok=0 for 3 cycles, then jr_data=32'h8000_1234 with jr_data_ok=1 -> redir_valid rises the following cycle with redir_pc=32'h8000_1234.
  - Second run with no data for 16 cycles -> jr_err pulses once and no redir_valid is ever seen.
- ISSUE with stall=1 for 5 cycles -> redir_valid and redir_pc held and no flush; stall drops -> transfer and flush.
  - Async reset mid-ISSUE -> outputs return to reset values immediately.
- REDIR_STAT_EN defined, 3 redirects -> redir_cnt=3.
  - Macro undefined -> redir_cnt stays 0.
